// File: rtl/regfile_pkg.sv
// Shared Y86 definitions: register IDs, instruction codes and the stack base.
package regfile_pkg;

  localparam int unsigned NumRegs = 15;

  // Register IDs
  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] R8    = 4'h8;
  localparam logic [3:0] R9    = 4'h9;
  localparam logic [3:0] R10   = 4'hA;
  localparam logic [3:0] R11   = 4'hB;
  localparam logic [3:0] R12   = 4'hC;
  localparam logic [3:0] R13   = 4'hD;
  localparam logic [3:0] R14   = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [63:0] STACK_BASE_DEFAULT = 64'h0000_0000_0000_0200;

  // True for any ID that names a real register
  function automatic logic is_reg(input logic [3:0] id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: RNONE returns zero, committing writes bypass the stored value.
module regfile_rdport
  import regfile_pkg::*;
(
  input  logic [3:0]  src_i,
  input  logic [63:0] stored_i,
  input  logic        we_e_i,
  input  logic [3:0]  dst_e_i,
  input  logic [63:0] val_e_i,
  input  logic        we_m_i,
  input  logic [3:0]  dst_m_i,
  input  logic [63:0] val_m_i,
  output logic [63:0] val_o
);

  // M-port checked first so it wins when both destinations match
  always_comb begin
    val_o = stored_i;
    if (!is_reg(src_i)) begin
      val_o = '0;
    end else if (we_m_i && (dst_m_i == src_i)) begin
      val_o = val_m_i;
    end else if (we_e_i && (dst_e_i == src_i)) begin
      val_o = val_e_i;
    end
  end

endmodule

// File: rtl/regfile.sv
// Y86 register file: 15 x 64-bit registers, two write ports (E, M), two bypassed read ports.
module regfile
  import regfile_pkg::*;
#(
  parameter logic [63:0] STACK_BASE = STACK_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [3:0]  dstE,
  input  logic [63:0] valE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valM,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [31:0] wr_count
);

  logic [63:0] regs_q [NumRegs];
  logic [63:0] regs_d [NumRegs];
  logic [31:0] wr_count_q, wr_count_d;
  logic        we_e, we_m;
  logic [63:0] stored_a, stored_b;

  // Write enables are blocked during reset, so neither storage nor bypass sees them
  assign we_e = rst_n && instr_valid && is_reg(dstE);
  assign we_m = rst_n && instr_valid && is_reg(dstM);

  // Next-state: reset image, else E then M writes (M applied last takes priority)
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_d[i] = (4'(i) == RRSP) ? STACK_BASE : 64'h0;
      end
      wr_count_d = '0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (we_e && (dstE == 4'(i))) regs_d[i] = valE;
        if (we_m && (dstM == 4'(i))) regs_d[i] = valM;
      end
      if (we_e || we_m) wr_count_d = wr_count_q + 32'd1;
    end
  end

  // State register with synchronous active-low reset folded into next-state logic
  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    wr_count_q <= wr_count_d;
  end

  // Stored-value lookup; ID 15 has no storage and falls through to zero
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (srcA == 4'(i)) stored_a = regs_q[i];
      if (srcB == 4'(i)) stored_b = regs_q[i];
    end
  end

  regfile_rdport u_rdport_a (
    .src_i    (srcA),
    .stored_i (stored_a),
    .we_e_i   (we_e),
    .dst_e_i  (dstE),
    .val_e_i  (valE),
    .we_m_i   (we_m),
    .dst_m_i  (dstM),
    .val_m_i  (valM),
    .val_o    (valA)
  );

  regfile_rdport u_rdport_b (
    .src_i    (srcB),
    .stored_i (stored_b),
    .we_e_i   (we_e),
    .dst_e_i  (dstE),
    .val_e_i  (valE),
    .we_m_i   (we_m),
    .dst_m_i  (dstM),
    .val_m_i  (valM),
    .val_o    (valB)
  );

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, hand sequence, random vs model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [3:0]  dstE, dstM, srcA, srcB;
  logic [63:0] valE, valM;
  logic [63:0] valA, valB;
  logic [31:0] wr_count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference model: plain array of register values plus a commit counter
  logic [63:0] m_regs [15];
  logic [31:0] m_cnt;

  regfile #(.STACK_BASE(64'h0000_0000_0000_0200)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .dstE        (dstE),
    .valE        (valE),
    .dstM        (dstM),
    .valM        (valM),
    .srcA        (srcA),
    .srcB        (srcB),
    .valA        (valA),
    .valB        (valB),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [3:0]  dst_e;
    logic [63:0] val_e;
    logic [3:0]  dst_m;
    logic [63:0] val_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Value a read of s should return right now, from the rules: RNONE -> 0,
  // a committing M write wins, then a committing E write, else the stored value
  function automatic logic [63:0] m_read(input logic [3:0] s);
    logic commit;
    commit = rst_n && instr_valid;
    if (s == 4'hF) return 64'h0;
    if (commit && dstM == s) return valM;
    if (commit && dstE == s) return valE;
    return m_regs[s];
  endfunction

  // Apply what the current inputs do on a clock edge to the model
  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? 64'h200 : 64'h0;
      m_cnt = 0;
    end else if (instr_valid && (dstE != 4'hF || dstM != 4'hF)) begin
      if (dstE != 4'hF) m_regs[dstE] = valE;
      if (dstM != 4'hF) m_regs[dstM] = valM; // overwrites E on conflict
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    @(negedge clk);
    rst_n = r; instr_valid = iv; dstE = de; valE = ve; dstM = dm; valM = vm;
    srcA = sa; srcB = sb;
    #1;
  endtask

  task automatic edge_and_model();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    // Rows: inputs applied, then pre-edge expected valA/valB/wr_count, then the edge
    vecs.push_back('{1, 0, 4'hF, 64'h0,   4'hF, 64'h0,    4'h4, 4'h0, 64'h200,  64'h0,  32'd0});
    vecs.push_back('{1, 1, 4'h2, 64'h11,  4'h3, 64'h22,   4'h2, 4'h3, 64'h11,   64'h22, 32'd0});
    vecs.push_back('{1, 0, 4'hF, 64'h0,   4'hF, 64'h0,    4'h2, 4'h3, 64'h11,   64'h22, 32'd1});
    vecs.push_back('{1, 1, 4'h4, 64'h1F8, 4'h4, 64'hDEAD, 4'h4, 4'hF, 64'hDEAD, 64'h0,  32'd1});
    vecs.push_back('{1, 0, 4'hF, 64'h0,   4'hF, 64'h0,    4'h4, 4'h2, 64'hDEAD, 64'h11, 32'd2});
    vecs.push_back('{1, 1, 4'h5, 64'h77,  4'hF, 64'h0,    4'h5, 4'h1, 64'h77,   64'h0,  32'd2});
    vecs.push_back('{1, 0, 4'h1, 64'h99,  4'hF, 64'h0,    4'h5, 4'h1, 64'h77,   64'h0,  32'd3});
    vecs.push_back('{1, 1, 4'hF, 64'h5,   4'hF, 64'h6,    4'h1, 4'hF, 64'h0,    64'h0,  32'd3});
    vecs.push_back('{1, 0, 4'hF, 64'h0,   4'hF, 64'h0,    4'hF, 4'h1, 64'h0,    64'h0,  32'd3});
    vecs.push_back('{0, 1, 4'h2, 64'h55,  4'hF, 64'h0,    4'h2, 4'h4, 64'h11,   64'hDEAD, 32'd3});
    vecs.push_back('{1, 0, 4'hF, 64'h0,   4'hF, 64'h0,    4'h2, 4'h4, 64'h0,    64'h200, 32'd0});
    vecs.push_back('{1, 1, 4'h6, 64'hAB,  4'hF, 64'h0,    4'h6, 4'hF, 64'hAB,   64'h0,  32'd0});
    vecs.push_back('{1, 0, 4'hF, 64'h0,   4'hF, 64'h0,    4'h6, 4'h4, 64'hAB,   64'h200, 32'd1});

    // Initial reset edge
    drive(0, 1, 4'h2, 64'h55, 4'h3, 64'h66, 4'h0, 4'h0);
    edge_and_model();

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].iv, vecs[i].dst_e, vecs[i].val_e, vecs[i].dst_m,
            vecs[i].val_m, vecs[i].src_a, vecs[i].src_b);
      check($sformatf("vec%0d valA", i), valA, vecs[i].exp_a);
      check($sformatf("vec%0d valB", i), valB, vecs[i].exp_b);
      check($sformatf("vec%0d wr_count", i), {32'h0, wr_count}, {32'h0, vecs[i].exp_cnt});
      edge_and_model();
    end

    // Back-to-back writes to one register: second value bypasses, then sticks
    drive(1, 1, 4'h8, 64'hAAAA, 4'hF, 64'h0, 4'h8, 4'h8);
    edge_and_model();
    drive(1, 1, 4'hF, 64'h0, 4'h8, 64'hBBBB, 4'h8, 4'h0);
    check("b2b bypass", valA, 64'hBBBB);
    edge_and_model();
    drive(1, 0, 4'h8, 64'hCCCC, 4'h8, 64'hDDDD, 4'h8, 4'h8);
    check("b2b hold", valB, 64'hBBBB);
    check("b2b count", {32'h0, wr_count}, 64'd3);
    edge_and_model();

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      logic [3:0] de, dm;
      de = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      dm = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) dm = de;
      drive(($urandom_range(0, 39) != 0), 1'($urandom), de, {$urandom, $urandom}, dm,
            {$urandom, $urandom}, 4'($urandom), 4'($urandom));
      check($sformatf("rnd%0d valA", n), valA, m_read(srcA));
      check($sformatf("rnd%0d valB", n), valB, m_read(srcB));
      check($sformatf("rnd%0d wr_count", n), {32'h0, wr_count}, {32'h0, m_cnt});
      edge_and_model();
    end

    // Final sweep of every register through port A with writes idle
    for (int r = 0; r < 16; r++) begin
      drive(1, 0, 4'hF, 64'h0, 4'hF, 64'h0, 4'(r), 4'hF);
      check($sformatf("final r%0d", r), valA, m_read(4'(r)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: STACK_BASE, 64'h0000_0000_0000_0200, reset value of %rsp (register 4).
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 instr_valid  input  1  qualifies both write ports this cycle.
REQ-005 dstE  input  4  E-port destination register ID; 4'hF = RNONE (no write).
REQ-006 valE  input  64  E-port write data (ALU result).
REQ-007 dstM  input  4  M-port destination register ID; 4'hF = RNONE.
REQ-008 valM  input  64  M-port write data (memory result).
REQ-009 srcA  input  4  read port A register ID; 4'hF = RNONE.
REQ-010 srcB  input  4  read port B register ID; 4'hF = RNONE.
REQ-011 valA  output  64  read port A data.
REQ-012 valB  output  64  read port B data.
REQ-013 wr_count  output  32  number of clock edges that committed at least one register write.

Function
REQ-014 Storage SHALL be 15 registers of 64 bits, IDs 0..14 (%rax..%r14); ID 15 SHALL have no storage.
REQ-015 Writes SHALL commit on the rising clk edge when rst_n=1, instr_valid=1 and the destination is not RNONE.
REQ-016 The E-port and M-port SHALL commit independently in the same edge when dstE != dstM.
REQ-017 When dstE == dstM (not RNONE), only valM SHALL be written (M-port priority; popq %rsp semantics).
REQ-018 With instr_valid=0 no register SHALL change, regardless of dstE/dstM.
REQ-019 valA/valB SHALL be combinational reads of srcA/srcB with zero cycles latency.
REQ-020 Reading RNONE SHALL return 64'h0.
REQ-021 Read-during-write: when srcX matches a destination committing this cycle, valX SHALL return the value being written (M-port value if both match), not the stale value.
REQ-022 After a write commits, all subsequent reads of that register SHALL return the written value until the next write.
REQ-023 wr_count SHALL increment by exactly 1 per committing edge (even when both ports write); it SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-024 Out-of-range values are impossible (4-bit IDs); ID 15 on a destination SHALL be silently ignored, with no wr_count increment if neither port writes.

Reset
REQ-025 On a rising edge with rst_n=0, registers 0..14 except 4 SHALL become 64'h0, register 4 SHALL become STACK_BASE, wr_count SHALL become 0.
REQ-026 Reset SHALL take priority over any simultaneous write; no write in a reset cycle SHALL commit.
REQ-027 During reset, valA/valB SHALL reflect stored contents, with no bypass of the blocked write.
REQ-028 Deasserting reset mid-program SHALL require no further initialisation; the first edge with rst_n=1 may commit writes.

Structure
REQ-029 Register ID constants (RRAX..R14, RRSP=4, RNONE=4'hF) SHALL live in the shared Y86 package alongside icode constants.
REQ-030 STACK_BASE default SHALL be defined in that package and referenced by the parameter default.
REQ-031 One sub-module SHALL be used: regfile_rdport (ID + bypass inputs -> 64-bit data), instantiated twice for A and B.
REQ-032 Storage and wr_count SHALL be the only state; no internal FSM.

Verification
REQ-033 Reset: hold rst_n=0 one edge, then srcA=4, srcB=0 -> valA=64'h200, valB=0, wr_count=0.
REQ-034 Dual write: instr_valid=1, dstE=2 valE=64'h11, dstM=3 valM=64'h22, one edge; srcA=2 srcB=3 -> valA=64'h11, valB=64'h22, wr_count=1.
REQ-035 Conflict: dstE=dstM=4, valE=64'h1F8, valM=64'hDEAD, one edge -> register 4 reads 64'hDEAD, wr_count increments by 1.
REQ-036 Bypass: srcA=5, dstE=5, valE=64'h77, before the edge -> valA=64'h77 combinationally; after the edge it is still 64'h77.
REQ-037 Gating: instr_valid=0, dstE=1 valE=64'h99 -> register 1 unchanged, wr_count unchanged; dstE=dstM=RNONE with instr_valid=1 -> no change; srcA=15 -> valA=0.
REQ-038 Reset priority: rst_n=0 with instr_valid=1, dstE=2, valE=64'h55 -> register 2 = 0 after the edge, wr_count=0.
